score_fill_sequencer: RTL
=========================

# score_fill_sequencer

Sequences the Needleman-Wunsch score-matrix fill, one cell at a time in row-major order.
- For each cell it drives the score-RAM read-index generator through the three neighbour reads (diag, up, left) and tells the cell-score calculator when each neighbour word is valid.
- It then starts the calculation, waits for the result and writes it back at (i+1, j+1).
- It sits between the top-level control FSM (start/done) and the score RAM, read-index generator and cell-score calculator.

## Interface
Parameters:
- N, 128, sequence length; matrix is (N+1)×(N+1), row 0 / col 0 pre-initialised.
- BitAddr, $clog2(N+1), index width is BitAddr+1.
- ADDR_W, $clog2((N+1)*(N+1)), write address width.
- SCORE_W, 16, score word width.

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to fill the matrix.
- calc_done  in  1  calculator result valid.
- score_in  in  SCORE_W  calculator result.
- en_read  out  1  read-index generator enable.
- count  out  2  neighbour select: 00 diag (i,j), 01 up (i,j+1), 10 left (i+1,j), 11 hold.
- change_index  out  1  index update in progress.
- i, j  out  BitAddr+1  top-left neighbour coordinates of the current cell.
- cap_sel  out  3  one-hot neighbour-data valid strobe (bit0 diag, bit1 up, bit2 left).
- calc_start  out  1  one-cycle calculator start.
- wr_en  out  1  score RAM write enable.
- wr_addr  out  ADDR_W+1  (j+1)+(N+1)*(i+1).
- wr_data  out  SCORE_W  latched score_in.
- busy  out  1  fill in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, READ, DRAIN, CALC, WRITE, NEXT, DONE.
- IDLE: all outputs 0 except count=11. start=1 → i=0, j=0, READ.
- READ (3 cycles): en_read=1, count=00, 01, 10 on successive cycles → DRAIN.
- DRAIN (2 cycles): en_read=0, count=11. Covers address register plus synchronous RAM read.
- cap_sel[k] asserts exactly 2 cycles after the cycle count=k was driven, for 1 cycle. It is generated by a delay pipe, independent of state.
- CALC: calc_start=1 in the first CALC cycle only. Remain until calc_done=1 is sampled; then latch score_in → wr_data and go to WRITE. calc_done in the start cycle itself is ignored.
- WRITE (1 cycle): wr_en=1, wr_addr computed from the current i, j.
  - Cell (N-1, N-1) → DONE.
  - Any other cell → NEXT.
- NEXT (1 cycle): change_index=1, count=11.
  - j<N-1 → j+1.
  - Otherwise j=0, i+1.
  - Then → READ.
- DONE (1 cycle): done=1 → IDLE.
- busy=1 in every state except IDLE.
- start while busy: ignored. calc_done outside CALC: ignored.
- wr_addr arithmetic is done at ADDR_W+1 bits; the maximum value N*(N+1)+N must not truncate.
- Reset mid-fill: immediate return to IDLE. All outputs and indices are 0 and count=11. No write is issued and no done pulse.

## Timing
- With the start cycle as c0, READ occupies c1-c3. cap_sel bits 0/1/2 are high in c3/c4/c5. DRAIN is c4-c5, and calc_start is in c6.
- Per cell, the minimum is 9 cycles: READ 3 + DRAIN 2 + CALC 2 + WRITE 1 + NEXT 1. The last cell has no NEXT.
- Each extra cycle of calc_done latency adds 1 cycle.
- Minimum fill, start to done: 9·N² cycles. done is high in cycle 9·N² (last cell's NEXT replaced by DONE).
- i, j are stable from the cycle after NEXT through the end of the cell's WRITE.

## Configuration
- SCORE_SEQ_CYCLE_CNT_EN defined:
  - Adds output cycle_cnt [31:0].
  - Cleared on an accepted start; increments every busy cycle.
  - Holds its value after DONE until the next start; reset value 0.
- Undefined: no port, no counter logic.

## Test plan
- N=2, start, calc_done returned 1 cycle after calc_start → wr_addr sequence 4, 5, 7, 8; done at cycle 36 after start; busy low after.
- N=2, calc_done delayed 3 cycles per cell → each cell stretches by 2 cycles; done at cycle 44; wr_data equals score_in sampled at calc_done.
- Single cell: check count=00/01/10 on consecutive cycles; cap_sel=001/010/100 exactly 2 cycles later; change_index only in NEXT.
- start asserted during the fill and calc_done pulsed during READ → no restart, no premature WRITE; address sequence unchanged.
- rst asserted in CALC of cell (0,1) → next cycle IDLE, wr_en=0, i=j=0, done never pulses; a new start refills from cell (0,0).
- With SCORE_SEQ_CYCLE_CNT_EN, N=2, minimum calc latency → cycle_cnt=36 after done and held; an accepted start clears it.

Source files
------------

// File: rtl/score_fill_sequencer.sv
// Row-major Needleman-Wunsch score-matrix fill sequencer: neighbour reads, calc handshake, write-back.
// Optional SCORE_SEQ_CYCLE_CNT_EN adds a busy-cycle counter output cycle_cnt.
module score_fill_sequencer #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1),
    parameter int ADDR_W  = $clog2((N + 1) * (N + 1)),
    parameter int SCORE_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 calc_done,
    input  logic [SCORE_W-1:0]   score_in,
    output logic                 en_read,
    output logic [1:0]           count,
    output logic                 change_index,
    output logic [BitAddr:0]     i,
    output logic [BitAddr:0]     j,
    output logic [2:0]           cap_sel,
    output logic                 calc_start,
    output logic                 wr_en,
    output logic [ADDR_W:0]      wr_addr,
    output logic [SCORE_W-1:0]   wr_data,
    output logic                 busy,
    output logic                 done
`ifdef SCORE_SEQ_CYCLE_CNT_EN
    ,
    output logic [31:0]          cycle_cnt
`endif
);

    localparam int IW = BitAddr + 1;
    localparam int AW = ADDR_W + 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, CALC, WRITE, NEXT, DONE} state_t;

    state_t        state;
    logic          drain_second;
    logic [2:0]    cap_pipe;
    logic [AW-1:0] addr_next;

    always_comb begin
        addr_next = AW'(j) + AW'(1) + AW'(N + 1) * (AW'(i) + AW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            drain_second <= 1'b0;
            en_read      <= 1'b0;
            count        <= 2'b11;
            change_index <= 1'b0;
            i            <= '0;
            j            <= '0;
            calc_start   <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            en_read      <= 1'b0;
            count        <= 2'b11;
            change_index <= 1'b0;
            calc_start   <= 1'b0;
            wr_en        <= 1'b0;
            done         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        i       <= '0;
                        j       <= '0;
                        busy    <= 1'b1;
                        en_read <= 1'b1;
                        count   <= 2'b00;
                        state   <= READ;
                    end
                end
                // count itself tracks progress through the three neighbour reads
                READ: begin
                    if (count == 2'b00) begin
                        en_read <= 1'b1;
                        count   <= 2'b01;
                    end else if (count == 2'b01) begin
                        en_read <= 1'b1;
                        count   <= 2'b10;
                    end else begin
                        drain_second <= 1'b0;
                        state        <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!drain_second) begin
                        drain_second <= 1'b1;
                    end else begin
                        drain_second <= 1'b0;
                        calc_start   <= 1'b1;
                        state        <= CALC;
                    end
                end
                // calc_start is high only in the first CALC cycle; calc_done is ignored there
                CALC: begin
                    if (!calc_start && calc_done) begin
                        wr_data <= score_in;
                        wr_addr <= addr_next;
                        wr_en   <= 1'b1;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (i == LAST && j == LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        change_index <= 1'b1;
                        state        <= NEXT;
                    end
                end
                NEXT: begin
                    if (j < LAST) begin
                        j <= j + IW'(1);
                    end else begin
                        j <= '0;
                        i <= i + IW'(1);
                    end
                    en_read <= 1'b1;
                    count   <= 2'b00;
                    state   <= READ;
                end
                DONE: begin
                    busy    <= 1'b0;
                    i       <= '0;
                    j       <= '0;
                    wr_addr <= '0;
                    wr_data <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture strobes lag the driven neighbour select by the address register plus RAM read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_pipe <= '0;
            cap_sel  <= '0;
        end else begin
            case (count)
                2'b00:   cap_pipe <= 3'b001;
                2'b01:   cap_pipe <= 3'b010;
                2'b10:   cap_pipe <= 3'b100;
                default: cap_pipe <= 3'b000;
            endcase
            cap_sel <= cap_pipe;
        end
    end

`ifdef SCORE_SEQ_CYCLE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (state == IDLE && start) begin
            cycle_cnt <= '0;
        end else if (busy) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule
